seq_divider: RTL

Parametrised sequential restoring divider for the ALU, generalising the fixed 4-bit division controller into a complete unit with the datapath included. It accepts WIDTH-bit unsigned operands (signed optional), produces one quotient bit per clock, and reports divide-by-zero. It sits beside the adder and multiplier in the ALU and uses a go/busy/done handshake to talk to the ALU sequencer.

---
 rtl/seq_divider.sv | 117 +++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// seq_divider: restoring divider, one quotient bit per clock; define SEQ_DIVIDER_SIGNED_EN for two's-complement operands
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
`ifdef SEQ_DIVIDER_SIGNED_EN
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif
  state_t state, next;
  logic [WIDTH-1:0] dvd, dvs, acc, a_mag, b_mag;
  logic [WIDTH:0] p, diff;
  logic [CW-1:0] cnt;
  logic dz, qbit, last;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q, neg_r;
  assign a_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign b_mag = divisor[WIDTH-1] ? -divisor : divisor;
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
`endif
  // one restoring step: dvd doubles as dividend shifter and quotient collector
  always_comb begin
    p = {acc, dvd[WIDTH-1]};
    diff = p - {1'b0, dvs};
    qbit = ~diff[WIDTH];
    last = cnt == CW'(WIDTH - 1);
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= next;
  end
  // next-state and busy decode
  always_comb begin
    next = state;
    busy = 1'b0;
    case (state)
      IDLE: next = go ? (divisor == '0 ? DONE : CALC) : IDLE;
      CALC: begin
        busy = 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
        next = last ? FIX : CALC;
`else
        next = last ? DONE : CALC;
`endif
      end
`ifdef SEQ_DIVIDER_SIGNED_EN
      FIX: begin
        busy = 1'b1;
        next = DONE;
      end
`endif
      DONE: next = IDLE;
      default: next = IDLE;
    endcase
  end
  // working registers: operand capture, iteration, sign fix-up
  always_ff @(posedge clk) begin
    if (state == IDLE && go) begin
      if (divisor == '0) begin
        dvd <= '1;
        acc <= dividend;
        dz <= 1'b1;
      end else begin
        dvd <= a_mag;
        dvs <= b_mag;
        acc <= '0;
        cnt <= '0;
        dz <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
        neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        neg_r <= dividend[WIDTH-1];
`endif
      end
    end else if (state == CALC) begin
      dvd <= {dvd[WIDTH-2:0], qbit};
      acc <= qbit ? diff[WIDTH-1:0] : p[WIDTH-1:0];
      cnt <= cnt + CW'(1);
    end
`ifdef SEQ_DIVIDER_SIGNED_EN
    else if (state == FIX) begin
      dvd <= neg_q ? -dvd : dvd;
      acc <= neg_r ? -acc : acc;
    end
`endif
  end
  // result registers change only when an operation completes
  always_ff @(posedge clk) begin
    if (reset) begin
      done <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= state == DONE;
      if (state == DONE) begin
        quotient <= dvd;
        remainder <= acc;
        div_by_zero <= dz;
      end
    end
  end
endmodule
